// File: rtl/stream_pkg.sv
// Shared stream definitions: consume modes, lane offsets and skid-stage state encoding.
package stream_pkg;

   // Per-channel consume modes for join/fork style blocks.
   localparam bit CONSUME_BEAT = 1'b0;
   localparam bit CONSUME_PKT  = 1'b1;

   // Skid stage occupancy, encoded as {main_valid, skid_valid}.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_BUSY  = 2'b10,
      SKID_FULL  = 2'b11
   } skid_state_e;

   // Bit offset of lane idx inside a packed multi-lane bus.
   function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned data_wd);
      return idx * data_wd;
   endfunction

endpackage

// File: rtl/stream_join_n_if.sv
// Bundle of the N-channel input streams and the joined output stream.
interface stream_join_n_if #(
   parameter int DATA_WD = 4,
   parameter int N_CH    = 2
);
   logic [N_CH*DATA_WD-1:0] s_data;
   logic [N_CH-1:0]         s_valid;
   logic                    s_last;
   logic [N_CH-1:0]         s_ready;
   logic [N_CH*DATA_WD-1:0] m_data;
   logic                    m_valid;
   logic                    m_last;
   logic                    m_ready;

   // Join block view: consumes the input channels, produces the joined stream.
   modport slave (
      input  s_data, s_valid, s_last, m_ready,
      output s_ready, m_data, m_valid, m_last
   );

   // Environment view: drives the input channels, consumes the joined stream.
   modport master (
      output s_data, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_valid, m_last
   );
endinterface

// File: rtl/stream_skid_reg.sv
// Two-entry valid/ready register slice: fully registered outputs, one beat per cycle.
module stream_skid_reg
   import stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             push, load_main, load_skid, main_from_skid;

   // Upstream may push whenever the overflow entry is free.
   assign in_ready  = (state_q != SKID_FULL);
   assign push      = in_valid && in_ready;
   assign out_valid = (state_q == SKID_BUSY) || (state_q == SKID_FULL);
   assign out_data  = main_q;

   // Occupancy state register.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rstn) state_q <= SKID_EMPTY;
      else       state_q <= state_d;
   end

   // Next occupancy and which entry captures data this cycle.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         SKID_EMPTY: begin
            if (push) begin
               state_d   = SKID_BUSY;
               load_main = 1'b1;
            end
         end
         SKID_BUSY: begin
            if (push && out_ready) begin
               load_main = 1'b1;
            end else if (push) begin
               state_d   = SKID_FULL;
               load_skid = 1'b1;
            end else if (out_ready) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (out_ready) begin
               state_d        = SKID_BUSY;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   // Payload entries; main feeds the output, skid absorbs the beat accepted while stalled.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: payload flops are reset on purpose so the output bus reads zero after reset.
      if (!rstn) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)           main_q <= in_data;
         else if (main_from_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_data;
      end
   end

endmodule

// File: rtl/stream_join_n.sv
// N-channel stream join: one beat from every channel forms one wide output beat.
// Packet-mode channels hold their beat for the whole ch0 packet and retire it with the last beat.
module stream_join_n
   import stream_pkg::*;
#(
   parameter int              DATA_WD  = 4,
   parameter int              N_CH     = 2,
   parameter bit              HAS_LAST = 1'b1,
   parameter logic [N_CH-1:0] PKT_MASK = N_CH'(2'b10),
   parameter bit              OUT_REG  = 1'b1,
   parameter int              CNT_WD   = 32
) (
   input  logic              clk,
   input  logic              rstn,
   stream_join_n_if.slave    io,
   output logic [CNT_WD-1:0] stat_beats
);

   localparam int BEAT_WD = N_CH * DATA_WD + 1;

   if (N_CH < 2) begin : g_bad_n_ch
      $error("stream_join_n: N_CH must be at least 2");
   end
   if (PKT_MASK[0] != CONSUME_BEAT) begin : g_bad_mask
      $error("stream_join_n: ch0 is the payload channel and must be consumed per beat");
   end

   logic               live_q;
   logic               all_valid, stage_rdy, join_ok, last_eff, out_fire;
   logic [N_CH-1:0]    pkt_mode, rdy;
   logic [BEAT_WD-1:0] in_beat;

   // Handshakes stay off until the first edge after reset, so s_ready and m_valid read 0 in reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) live_q <= 1'b0;
      else       live_q <= 1'b1;
   end

   // Without framing every channel degenerates to per-beat consumption.
   assign last_eff  = HAS_LAST && io.s_last;
   assign pkt_mode  = HAS_LAST ? PKT_MASK : '0;
   assign all_valid = live_q && (&io.s_valid);
   assign join_ok   = all_valid && stage_rdy;

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      // A packet lane is replicated into every beat and only retired with ch0's last beat.
      assign rdy[i] = join_ok && ((pkt_mode[i] == CONSUME_PKT) ? last_eff : 1'b1);
      assign in_beat[lane_lo(i, DATA_WD) +: DATA_WD] = io.s_data[lane_lo(i, DATA_WD) +: DATA_WD];
   end
   assign in_beat[BEAT_WD-1] = last_eff;
   assign io.s_ready         = rdy;

   if (OUT_REG) begin : g_reg
      logic [BEAT_WD-1:0] out_beat;
      logic               out_valid;

      stream_skid_reg #(.WIDTH(BEAT_WD)) u_skid (
         .clk      (clk),
         .rstn     (rstn),
         .in_data  (in_beat),
         .in_valid (all_valid),
         .in_ready (stage_rdy),
         .out_data (out_beat),
         .out_valid(out_valid),
         .out_ready(io.m_ready)
      );

      assign io.m_valid = out_valid;
      assign io.m_data  = out_beat[BEAT_WD-2:0];
      assign io.m_last  = out_beat[BEAT_WD-1];
   end else begin : g_comb
      assign stage_rdy  = io.m_ready;
      assign io.m_valid = all_valid;
      assign io.m_data  = live_q ? in_beat[BEAT_WD-2:0] : '0;
      assign io.m_last  = live_q && last_eff;
   end

   assign out_fire = io.m_valid && io.m_ready;

   // Output handshake counter; wraps silently.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         stat_beats <= '0;
      else if (out_fire) stat_beats <= stat_beats + CNT_WD'(1);
   end

endmodule
